// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: combinational hit path, 4-word line
// refill over the mem_readM/mem_readyM handshake, and snoop invalidation of written lines.
module icache_direct #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_LINES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req,
  input  logic [WORD_SIZE-1:0]   addr,
  output logic [WORD_SIZE-1:0]   inst,
  output logic                   hit,
  output logic                   mem_readM,
  output logic [WORD_SIZE-1:0]   mem_address,
  input  logic [4*WORD_SIZE-1:0] mem_data,
  input  logic                   mem_readyM,
  input  logic                   inv_valid,
  input  logic [WORD_SIZE-1:0]   inv_address,
  output logic [WORD_SIZE-1:0]   num_access,
  output logic [WORD_SIZE-1:0]   num_miss
);

  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - IDX - 2;

  typedef enum logic {S_IDLE = 1'b0, S_FETCH = 1'b1} state_t;

  state_t                 state;
  logic                   poison;
  logic [NUM_LINES-1:0]   valid_lines;
  logic [NUM_LINES-1:0]   valid_next;
  logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
  logic [4*WORD_SIZE-1:0] line_mem [NUM_LINES];

  logic [IDX-1:0]         req_idx, inv_idx, fill_idx;
  logic [TAG_W-1:0]       req_tag, inv_tag, fill_tag;
  logic [1:0]             req_off;
  logic [WORD_SIZE-1:0]   words [4];
  logic                   inv_kill, inv_line_hit, inv_fill_hit, fill;
  logic                   unused_bits;

  assign req_off  = addr[1:0];
  assign req_idx  = addr[IDX+1:2];
  assign req_tag  = addr[WORD_SIZE-1:IDX+2];
  assign inv_idx  = inv_address[IDX+1:2];
  assign inv_tag  = inv_address[WORD_SIZE-1:IDX+2];
  assign fill_idx = mem_address[IDX+1:2];
  assign fill_tag = mem_address[WORD_SIZE-1:IDX+2];

  // Word offsets only select within a line; they never take part in line matching.
  assign unused_bits = ^{inv_address[1:0], mem_address[1:0]};

  assign inv_kill     = inv_valid & (inv_idx == req_idx) & (inv_tag == req_tag);
  assign inv_line_hit = inv_valid & valid_lines[inv_idx] & (tag_mem[inv_idx] == inv_tag);
  assign inv_fill_hit = inv_valid & (inv_idx == fill_idx) & (inv_tag == fill_tag);
  assign fill         = (state == S_FETCH) & mem_readyM;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      words[k] = line_mem[req_idx][k*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Lookup stage: same-cycle hit and instruction select.
  always_comb begin
    hit  = req & (state == S_IDLE) & valid_lines[req_idx] &
           (tag_mem[req_idx] == req_tag) & ~inv_kill;
    inst = hit ? words[req_off] : '0;
  end

  // A write landing on the line being filled (now or earlier in FETCH) keeps it invalid.
  always_comb begin
    valid_next = valid_lines;
    if (inv_line_hit) valid_next[inv_idx] = 1'b0;
    if (fill)         valid_next[fill_idx] = ~(poison | inv_fill_hit);
  end

  // Control stage: FSM, valid bits, poison and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      poison      <= 1'b0;
      valid_lines <= '0;
      mem_readM   <= 1'b0;
      mem_address <= '0;
      num_access  <= '0;
      num_miss    <= '0;
    end else begin
      valid_lines <= valid_next;
      if (hit) num_access <= num_access + WORD_SIZE'(1);
      case (state)
        S_IDLE: begin
          poison <= 1'b0;
          if (req && !hit) begin
            state       <= S_FETCH;
            mem_readM   <= 1'b1;
            mem_address <= {addr[WORD_SIZE-1:2], 2'b00};
            num_miss    <= num_miss + WORD_SIZE'(1);
          end
        end
        S_FETCH: begin
          if (inv_fill_hit) poison <= 1'b1;
          if (mem_readyM) begin
            state     <= S_IDLE;
            mem_readM <= 1'b0;
            poison    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Fill stage: line payload and tag carry no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_mem[fill_idx] <= mem_data;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed vector table, reset-mid-fetch sequence,
// and randomized traffic checked against a line-residency reference model.
module tb_icache_direct;

  localparam int WS = 16;
  localparam int NL = 4;

  logic          clk, reset_n, req, hit, mem_readM, mem_readyM, inv_valid;
  logic [WS-1:0] addr, inst, mem_address, inv_address, num_access, num_miss;
  logic [4*WS-1:0] mem_data;

  icache_direct #(.WORD_SIZE(WS), .NUM_LINES(NL)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .inst(inst), .hit(hit),
    .mem_readM(mem_readM), .mem_address(mem_address), .mem_data(mem_data),
    .mem_readyM(mem_readyM), .inv_valid(inv_valid), .inv_address(inv_address),
    .num_access(num_access), .num_miss(num_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic req; logic [15:0] addr; logic iv; logic [15:0] ia;
    logic hit; logic rd; logic [15:0] maddr; logic [15:0] acc; logic [15:0] miss;
  } vec_t;
  vec_t vecs[$];

  // Memory responder state
  bit mem_manual, rand_mode;
  int mcnt, cur_lat;

  // Reference model: which line address each slot holds (-1 = none)
  int res_line[NL];
  bit m_busy, m_poison;
  int m_pend;
  logic [15:0] m_acc, m_miss, m_maddr;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [63:0] line_of(input logic [15:0] a);
    logic [63:0] d;
    for (int k = 0; k < 4; k++) d[k*16 +: 16] = mem_word({a[15:2], 2'b00} + 16'(k));
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_out(input logic eh, input logic [15:0] ei, input logic erd,
                           input logic [15:0] ema, input logic [15:0] eacc,
                           input logic [15:0] emiss);
    chk("hit", hit, eh);
    chk("inst", inst, ei);
    chk("mem_readM", mem_readM, erd);
    chk("mem_address", mem_address, ema);
    chk("num_access", num_access, eacc);
    chk("num_miss", num_miss, emiss);
  endtask

  task automatic add(input logic r, input logic [15:0] a, input logic iv, input logic [15:0] ia,
                     input logic h, input logic rd, input logic [15:0] ma,
                     input logic [15:0] acc, input logic [15:0] mi);
    vec_t v;
    v.req = r; v.addr = a; v.iv = iv; v.ia = ia; v.hit = h; v.rd = rd;
    v.maddr = ma; v.acc = acc; v.miss = mi;
    vecs.push_back(v);
  endtask

  task automatic wait_n(input int n, input logic [15:0] a, input logic [15:0] ma,
                        input logic [15:0] acc, input logic [15:0] mi);
    for (int k = 0; k < n; k++) add(1, a, 0, 0, 0, 1, ma, acc, mi);
  endtask

  // Called at the start of each cycle (negedge): decide this cycle's memory response.
  task automatic mem_drive();
    if (mem_manual) return;
    mem_readyM = 1'b0;
    if (mem_readM) begin
      mcnt++;
      if (mcnt > cur_lat) begin
        mem_readyM = 1'b1;
        mem_data   = line_of(mem_address);
        mcnt       = 0;
        cur_lat    = rand_mode ? int'($urandom_range(0, 4)) : 3;
      end
    end else begin
      mcnt = 0;
      if (rand_mode && $urandom_range(0, 19) == 0) begin
        mem_readyM = 1'b1;
        mem_data   = {$urandom, $urandom};
      end
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NL; s++) res_line[s] = -1;
    m_busy = 0; m_poison = 0; m_pend = 0;
    m_acc = 0; m_miss = 0; m_maddr = 0;
  endtask

  initial begin
    logic eh;
    logic got;
    int line, il;

    reset_n = 0; req = 0; addr = 0; inv_valid = 0; inv_address = 0;
    mem_readyM = 0; mem_data = 0; mem_manual = 0; rand_mode = 0; mcnt = 0; cur_lat = 3;

    // Directed table: memory latency 3, counters are values before the cycle's edge.
    add(1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0);
    wait_n(4, 16'h0000, 16'h0000, 0, 1);
    add(1, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 1);
    add(1, 16'h0001, 0, 0, 1, 0, 16'h0000, 1, 1);
    add(1, 16'h0002, 0, 0, 1, 0, 16'h0000, 2, 1);
    add(1, 16'h0003, 0, 0, 1, 0, 16'h0000, 3, 1);
    add(0, 16'h0000, 0, 0, 0, 0, 16'h0000, 4, 1);
    add(1, 16'h0010, 0, 0, 0, 0, 16'h0000, 4, 1);
    wait_n(4, 16'h0010, 16'h0010, 4, 2);
    add(1, 16'h0010, 0, 0, 1, 0, 16'h0010, 4, 2);
    add(1, 16'h0000, 0, 0, 0, 0, 16'h0010, 5, 2);
    wait_n(4, 16'h0000, 16'h0000, 5, 3);
    add(1, 16'h0000, 0, 0, 1, 0, 16'h0000, 5, 3);
    add(1, 16'h0004, 0, 0, 0, 0, 16'h0000, 6, 3);
    wait_n(4, 16'h0004, 16'h0004, 6, 4);
    add(1, 16'h0004, 0, 0, 1, 0, 16'h0004, 6, 4);
    add(1, 16'h0005, 1, 16'h0006, 0, 0, 16'h0004, 7, 4);
    wait_n(4, 16'h0005, 16'h0004, 7, 5);
    add(1, 16'h0005, 0, 0, 1, 0, 16'h0004, 7, 5);
    add(1, 16'h0004, 1, 16'h0008, 1, 0, 16'h0004, 8, 5);
    add(1, 16'h0004, 0, 0, 1, 0, 16'h0004, 9, 5);
    add(0, 16'h0000, 0, 0, 0, 0, 16'h0004, 10, 5);
    add(1, 16'h0002, 0, 0, 1, 0, 16'h0004, 10, 5);
    add(0, 16'h0000, 1, 16'h0003, 0, 0, 16'h0004, 11, 5);
    add(1, 16'h0000, 0, 0, 0, 0, 16'h0004, 11, 5);
    add(1, 16'h0000, 1, 16'h0001, 0, 1, 16'h0000, 11, 6);
    wait_n(3, 16'h0000, 16'h0000, 11, 6);
    add(1, 16'h0000, 0, 0, 0, 0, 16'h0000, 11, 6);
    wait_n(4, 16'h0000, 16'h0000, 11, 7);
    add(1, 16'h0000, 0, 0, 1, 0, 16'h0000, 11, 7);
    add(0, 16'h0000, 0, 0, 0, 0, 16'h0000, 12, 7);

    repeat (2) @(negedge clk);
    req = 1; addr = 0; #1;
    check_out(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1; req = 0;

    foreach (vecs[i]) begin
      cyc++;
      mem_drive();
      req = vecs[i].req; addr = vecs[i].addr;
      inv_valid = vecs[i].iv; inv_address = vecs[i].ia;
      #1;
      check_out(vecs[i].hit, vecs[i].hit ? mem_word(vecs[i].addr) : 16'h0,
                vecs[i].rd, vecs[i].maddr, vecs[i].acc, vecs[i].miss);
      @(negedge clk);
    end

    // Reset in the middle of a fetch, then a late memory response.
    cyc++;
    mem_drive(); inv_valid = 0; req = 1; addr = 16'h0020; #1;
    chk("hs_conflict_miss", hit, 0);
    @(negedge clk); cyc++;
    mem_manual = 1; mem_readyM = 0; req = 0; #1;
    chk("hs_fetching", mem_readM, 1);
    reset_n = 0; #1;
    chk("rst_readM", mem_readM, 0);
    chk("rst_address", mem_address, 0);
    chk("rst_access", num_access, 0);
    chk("rst_miss", num_miss, 0);
    req = 1; addr = 0; #1;
    chk("rst_hit", hit, 0);
    chk("rst_inst", inst, 0);
    @(negedge clk); cyc++;
    reset_n = 1; req = 0; mem_readyM = 1; mem_data = line_of(16'h0020); #1;
    chk("late_rdy_readM", mem_readM, 0);
    @(negedge clk); cyc++;
    mem_readyM = 0; req = 1; addr = 0; #1;
    chk("late_rdy_ignored", hit, 0);
    @(negedge clk); cyc++;
    req = 0; #1;
    chk("after_rst_readM", mem_readM, 1);
    chk("after_rst_address", mem_address, 0);
    chk("after_rst_miss", num_miss, 1);
    chk("after_rst_access", num_access, 0);
    mem_manual = 0; mcnt = 1; cur_lat = 3;
    @(negedge clk);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      cyc++;
      mem_drive(); req = 1; addr = 0; #1;
      if (hit === 1'b1) begin
        got = 1;
        chk("retry_inst", inst, mem_word(0));
      end else begin
        @(negedge clk);
      end
    end
    chk("retry_hit_seen", got, 1);

    // Randomized traffic against the reference model.
    @(negedge clk);
    reset_n = 0; req = 0; inv_valid = 0; mem_readyM = 0;
    @(negedge clk);
    reset_n = 1;
    model_reset();
    rand_mode = 1; mcnt = 0; cur_lat = 2;
    for (int n = 0; n < 3000; n++) begin
      cyc++;
      mem_drive();
      req  = ($urandom_range(0, 9) < 7);
      addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
      inv_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 2))
        0: inv_address = {addr[15:2], 2'($urandom_range(0, 3))};
        1: inv_address = 16'(m_pend << 2) | 16'($urandom_range(0, 3));
        default: inv_address = 16'($urandom_range(0, 63));
      endcase
      #1;
      line = int'(addr) >> 2;
      eh = req && !m_busy && (res_line[line % NL] == line) &&
           !(inv_valid && (int'(inv_address) >> 2) == line);
      check_out(eh, eh ? mem_word(addr) : 16'h0, m_busy, m_maddr, m_acc, m_miss);
      if (inv_valid) begin
        il = int'(inv_address) >> 2;
        if (res_line[il % NL] == il) res_line[il % NL] = -1;
        if (m_busy && m_pend == il) m_poison = 1;
      end
      if (m_busy) begin
        if (mem_readyM) begin
          res_line[m_pend % NL] = m_poison ? -1 : m_pend;
          m_busy = 0; m_poison = 0;
        end
      end else if (req && !eh) begin
        m_busy = 1; m_poison = 0; m_pend = line;
        m_miss = m_miss + 16'd1;
        m_maddr = 16'(line << 2);
      end
      if (eh) m_acc = m_acc + 16'd1;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
